// File: rtl/game_fsm_ctrl_pkg.sv
// Shared constants for the game flow controller: state encoding, key codes,
// scroll reload values and the pipe-select LFSR step.
package game_fsm_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [4:0] KEY_FLAP    = 5'h09;
  localparam logic [4:0] KEY_RESTART = 5'h0a;

  localparam logic signed [10:0] PIPE_INIT_X   = 11'sd650;
  localparam logic signed [10:0] PIPE_RELOAD_X = 11'sd640;
  localparam logic signed [10:0] PIPE_WRAP_X   = -11'sd200;
  localparam logic [9:0]         BACK_RELOAD_X = 10'd470;

  localparam logic [7:0] LFSR_SEED = 8'h5A;

  // Fibonacci form of x^8+x^6+x^5+x^4+1; feedback enters at bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/game_fsm_ctrl_tick.sv
// Scroll-tick period generator: free counter compared against a period that
// shrinks by TICK_STEP on every tick and saturates at TICK_MIN.
module game_tick_gen
  import game_fsm_ctrl_pkg::*;
#(
  parameter int unsigned TICK_INIT = 5_000_000,
  parameter int unsigned TICK_MIN  = 4_000_000,
  parameter int unsigned TICK_STEP = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_init,
  output logic o_fire
);

  localparam int PW = $clog2(TICK_INIT + 1);

  logic [PW-1:0] r_cnt;
  logic [PW-1:0] r_period;
  logic          w_at_period;

  assign w_at_period = (r_cnt == r_period);
  assign o_fire      = i_run && !i_init && w_at_period;

  always_ff @(posedge clk) begin
    if (!rst_n || i_init) begin
      r_cnt    <= '0;
      r_period <= PW'(TICK_INIT);
    end else if (i_run) begin
      if (w_at_period) begin
        r_cnt <= '0;
        // Compare at full width so TICK_MIN+TICK_STEP never truncates.
        r_period <= (32'(r_period) >= TICK_MIN + TICK_STEP) ?
                    r_period - PW'(TICK_STEP) : PW'(TICK_MIN);
      end else begin
        r_cnt <= r_cnt + PW'(1);
      end
    end
  end

endmodule

// File: rtl/game_fsm_ctrl.sv
// Game flow controller: IDLE/PLAY/PAUSE/OVER FSM, key edge detection, scrolling
// and scoring. Define GAME_FSM_CTRL_HISCORE_EN to add the persistent hiscore output.
module game_fsm_ctrl
  import game_fsm_ctrl_pkg::*;
#(
  parameter int unsigned TICK_INIT = 5_000_000,
  parameter int unsigned TICK_MIN  = 4_000_000,
  parameter int unsigned TICK_STEP = 5000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               gamestart,
  input  logic               gamepause,
  input  logic [4:0]         up,
  input  logic               hit,
  output logic [1:0]         state,
  output logic               scroll_tick,
  output logic               flap,
  output logic               restart,
  output logic [9:0]         back_x,
  output logic signed [10:0] pipe_x,
  output logic               pipe_sel,
  output logic [15:0]        count,
  output logic [31:0]        score
`ifdef GAME_FSM_CTRL_HISCORE_EN
  ,
  output logic [31:0]        hiscore
`endif
);

  logic [1:0]         r_state;
  logic [4:0]         r_up_q;
  logic [7:0]         r_lfsr;
  logic               r_scroll_tick;
  logic               r_flap;
  logic               r_restart;
  logic [9:0]         r_back_x;
  logic signed [10:0] r_pipe_x;
  logic               r_pipe_sel;
  logic [15:0]        r_count;
  logic [31:0]        r_score;

  logic       w_flap_evt;
  logic       w_rst_evt;
  logic [1:0] w_next;
  logic       w_reinit;
  logic       w_restart;
  logic       w_tick;

  assign w_flap_evt = (up == KEY_FLAP) && (r_up_q != KEY_FLAP);
  assign w_rst_evt  = (up == KEY_RESTART) && (r_up_q != KEY_RESTART);

  // Priority: gamestart low, then game entry / restart, then per-state moves.
  always_comb begin
    w_next    = r_state;
    w_reinit  = 1'b0;
    w_restart = 1'b0;
    if (!gamestart) begin
      w_next = ST_IDLE;
    end else if (r_state == ST_IDLE) begin
      w_next   = ST_PLAY;
      w_reinit = 1'b1;
    end else if (w_rst_evt) begin
      w_next    = gamepause ? ST_PAUSE : ST_PLAY;
      w_reinit  = 1'b1;
      w_restart = 1'b1;
    end else begin
      case (r_state)
        ST_PLAY: begin
          if (hit)            w_next = ST_OVER;
          else if (gamepause) w_next = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (!gamepause) w_next = ST_PLAY;
        end
        default: w_next = r_state;
      endcase
    end
  end

  game_tick_gen #(
    .TICK_INIT (TICK_INIT),
    .TICK_MIN  (TICK_MIN),
    .TICK_STEP (TICK_STEP)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_run  (r_state == ST_PLAY),
    .i_init (w_reinit),
    .o_fire (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_up_q        <= '0;
      r_lfsr        <= LFSR_SEED;
      r_scroll_tick <= 1'b0;
      r_flap        <= 1'b0;
      r_restart     <= 1'b0;
      r_back_x      <= '0;
      r_pipe_x      <= PIPE_INIT_X;
      r_pipe_sel    <= 1'b0;
      r_count       <= '0;
      r_score       <= '0;
    end else begin
      r_state       <= w_next;
      r_up_q        <= up;
      r_lfsr        <= lfsr_next(r_lfsr);
      r_scroll_tick <= w_tick;
      r_flap        <= (r_state == ST_PLAY) && w_flap_evt;
      r_restart     <= w_restart;
      if (w_reinit) begin
        r_back_x   <= '0;
        r_pipe_x   <= PIPE_INIT_X;
        r_pipe_sel <= 1'b0;
        r_count    <= '0;
        r_score    <= '0;
      end else if (w_tick) begin
        r_score  <= r_score + 32'd1;
        r_back_x <= (r_back_x == 10'd0) ? BACK_RELOAD_X : r_back_x - 10'd10;
        if (r_pipe_x <= PIPE_WRAP_X) begin
          r_pipe_x   <= PIPE_RELOAD_X;
          r_pipe_sel <= r_lfsr[0];
          r_count    <= r_count + 16'd1;
        end else begin
          r_pipe_x <= r_pipe_x - 11'sd10;
        end
      end
    end
  end

`ifdef GAME_FSM_CTRL_HISCORE_EN
  logic [31:0] r_hiscore;

  // Survives restarts; only rst_n clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hiscore <= '0;
    end else if (r_state == ST_PLAY && w_next == ST_OVER && r_score > r_hiscore) begin
      r_hiscore <= r_score;
    end
  end

  assign hiscore = r_hiscore;
`endif

  assign state       = r_state;
  assign scroll_tick = r_scroll_tick;
  assign flap        = r_flap;
  assign restart     = r_restart;
  assign back_x      = r_back_x;
  assign pipe_x      = r_pipe_x;
  assign pipe_sel    = r_pipe_sel;
  assign count       = r_count;
  assign score       = r_score;

endmodule

// File: tb/tb_game_fsm_ctrl.sv
// Directed bench for game_fsm_ctrl with TICK_INIT=20, TICK_MIN=10, TICK_STEP=5.
module tb_game_fsm_ctrl;

  logic               clk;
  logic               rst_n;
  logic               gamestart;
  logic               gamepause;
  logic [4:0]         up;
  logic               hit;
  logic [1:0]         state;
  logic               scroll_tick;
  logic               flap;
  logic               restart;
  logic [9:0]         back_x;
  logic signed [10:0] pipe_x;
  logic               pipe_sel;
  logic [15:0]        count;
  logic [31:0]        score;
`ifdef GAME_FSM_CTRL_HISCORE_EN
  logic [31:0]        hiscore;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  game_fsm_ctrl #(
    .TICK_INIT (20),
    .TICK_MIN  (10),
    .TICK_STEP (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gamestart   (gamestart),
    .gamepause   (gamepause),
    .up          (up),
    .hit         (hit),
    .state       (state),
    .scroll_tick (scroll_tick),
    .flap        (flap),
    .restart     (restart),
    .back_x      (back_x),
    .pipe_x      (pipe_x),
    .pipe_sel    (pipe_sel),
    .count       (count),
    .score       (score)
`ifdef GAME_FSM_CTRL_HISCORE_EN
    ,
    .hiscore     (hiscore)
`endif
  );

  // Clock and reference LFSR (x^8+x^6+x^5+x^4+1, seed 5A, feedback into bit 0)
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] m_lfsr;
  logic [7:0] m_lfsr_prev;
  always @(posedge clk) begin
    m_lfsr_prev <= m_lfsr;
    if (!rst_n) m_lfsr <= 8'h5A;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until scroll_tick is seen; n is the number of edges taken (bounded).
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!scroll_tick && n < 200);
  endtask

  int n;
  int ticks;
  int flaps;
  int rsts;
  int iter;

  initial begin
    rst_n = 1'b0; gamestart = 1'b0; gamepause = 1'b0; up = 5'd0; hit = 1'b0;
    repeat (3) step();

    check("rst_state",    32'(state), 0);
    check("rst_tick",     32'(scroll_tick), 0);
    check("rst_flap",     32'(flap), 0);
    check("rst_restart",  32'(restart), 0);
    check("rst_back_x",   32'(back_x), 0);
    check("rst_pipe_x",   32'($signed(pipe_x)), 650);
    check("rst_pipe_sel", 32'(pipe_sel), 0);
    check("rst_count",    32'(count), 0);
    check("rst_score",    32'(score), 0);
`ifdef GAME_FSM_CTRL_HISCORE_EN
    check("rst_hiscore",  hiscore, 0);
`endif

    rst_n = 1'b1;
    step();
    check("idle_hold", 32'(state), 0);
    gamestart = 1'b1;
    step();
    check("enter_play", 32'(state), 1);

    // Period shrinks 20 -> 15 -> 10 and then saturates.
    wait_tick(n);
    check("tick1_gap",    32'(n), 21);
    check("tick1_score",  score, 1);
    check("tick1_pipe_x", 32'($signed(pipe_x)), 640);
    check("tick1_back_x", 32'(back_x), 470);
    wait_tick(n);
    check("tick2_gap",    32'(n), 16);
    check("tick2_score",  score, 2);
    check("tick2_back_x", 32'(back_x), 460);
    wait_tick(n);
    check("tick3_gap",    32'(n), 11);
    wait_tick(n);
    check("tick4_gap",    32'(n), 11);
    check("tick4_pipe_x", 32'($signed(pipe_x)), 610);
    step();
    check("tick_one_cycle", 32'(scroll_tick), 0);

    // Run the pipe down to the wrap threshold, then wrap it.
    iter = 0;
    while ($signed(pipe_x) != -200 && iter < 100) begin
      wait_tick(n);
      iter++;
    end
    check("pipe_at_wrap", 32'($signed(pipe_x)), -200);
    check("count_prewrap", 32'(count), 0);
    wait_tick(n);
    check("wrap_gap",      32'(n), 11);
    check("wrap_pipe_x",   32'($signed(pipe_x)), 640);
    check("wrap_count",    32'(count), 1);
    check("wrap_pipe_sel", 32'(pipe_sel), 32'(m_lfsr_prev[0]));
    check("wrap_score",    score, 86);
    check("wrap_back_x",   32'(back_x), 100);

    // Pause 5 cycles into a period; flap key held during the pause.
    repeat (4) step();
    gamepause = 1'b1;
    step();
    check("enter_pause", 32'(state), 2);
    ticks = 0; flaps = 0;
    up = 5'h09;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) up = 5'd0;
      step();
      if (scroll_tick) ticks++;
      if (flap) flaps++;
    end
    check("pause_ticks",  32'(ticks), 0);
    check("pause_flaps",  32'(flaps), 0);
    check("pause_state",  32'(state), 2);
    check("pause_score",  score, 86);
    check("pause_pipe_x", 32'($signed(pipe_x)), 640);
    check("pause_back_x", 32'(back_x), 100);
    gamepause = 1'b0;
    step();
    check("resume_state", 32'(state), 1);
    wait_tick(n);
    check("resume_gap",    32'(n), 6);
    check("resume_score",  score, 87);
    check("resume_pipe_x", 32'($signed(pipe_x)), 630);
    check("resume_back_x", 32'(back_x), 90);

    // Held flap key in PLAY gives a single pulse.
    ticks = 0; flaps = 0;
    up = 5'h09;
    for (int i = 0; i < 50; i++) begin
      step();
      if (scroll_tick) ticks++;
      if (flap) flaps++;
    end
    up = 5'd0;
    check("play_flaps", 32'(flaps), 1);
    check("play_ticks", 32'(ticks), 4);
    wait_tick(n);
    check("post_flap_gap",    32'(n), 5);
    check("post_flap_score",  score, 92);
    check("post_flap_pipe_x", 32'($signed(pipe_x)), 580);
    check("post_flap_back_x", 32'(back_x), 40);

    // Hit wins over gamepause; OVER freezes scrolling.
    hit = 1'b1; gamepause = 1'b1;
    step();
    check("hit_over", 32'(state), 3);
    hit = 1'b0; gamepause = 1'b0;
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (scroll_tick) ticks++;
    end
    check("over_ticks",  32'(ticks), 0);
    check("over_state",  32'(state), 3);
    check("over_score",  score, 92);
    check("over_pipe_x", 32'($signed(pipe_x)), 580);
    check("over_back_x", 32'(back_x), 40);
`ifdef GAME_FSM_CTRL_HISCORE_EN
    check("hiscore_92", hiscore, 92);
`endif

    // Held restart key: one pulse, game reinitialised in PLAY.
    rsts = 0;
    up = 5'h0a;
    for (int i = 0; i < 5; i++) begin
      step();
      if (restart) rsts++;
    end
    up = 5'd0;
    check("restart_pulses", 32'(rsts), 1);
    check("restart_state",  32'(state), 1);
    check("restart_score",  score, 0);
    check("restart_count",  32'(count), 0);
    check("restart_pipe_x", 32'($signed(pipe_x)), 650);
    check("restart_back_x", 32'(back_x), 0);
    wait_tick(n);
    check("restart_gap",    32'(n), 17);
    check("restart_score1", score, 1);

    // Reset in the same cycle as a flap event leaves no strobe behind.
    up = 5'h09; rst_n = 1'b0;
    step();
    check("midrst_flap",  32'(flap), 0);
    check("midrst_state", 32'(state), 0);
    check("midrst_score", score, 0);
    rst_n = 1'b1;
    step();
    check("postrst_flap",    32'(flap), 0);
    check("postrst_tick",    32'(scroll_tick), 0);
    check("postrst_restart", 32'(restart), 0);
    check("postrst_state",   32'(state), 1);
    up = 5'd0;
`ifdef GAME_FSM_CTRL_HISCORE_EN
    check("postrst_hiscore", hiscore, 0);
`endif

    // Score 7, lose; restart, score 3, lose.
    repeat (7) wait_tick(n);
    check("game1_score", score, 7);
    hit = 1'b1;
    step();
    hit = 1'b0;
    check("game1_over", 32'(state), 3);
    up = 5'h0a;
    step();
    up = 5'd0;
    check("game2_state", 32'(state), 1);
    repeat (3) wait_tick(n);
    check("game2_score", score, 3);
    hit = 1'b1;
    step();
    hit = 1'b0;
    check("game2_over", 32'(state), 3);
`ifdef GAME_FSM_CTRL_HISCORE_EN
    check("hiscore_7", hiscore, 7);
`endif

    gamestart = 1'b0;
    step();
    check("drop_idle", 32'(state), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
